// File: rtl/handwash_valve_controller.sv
// Water valve sequencer for the handwash sensor: debounce, hold-open, max-on lockout, wash counting.
// Optional soap dispense phase before water is enabled by defining SOAP_DISPENSE_EN.
module handwash_valve_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES     = 5000000,
  parameter int unsigned MAX_ON_DEFAULT  = 300000000,
  parameter int unsigned SOAP_CYCLES     = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waterRequest,
  input  logic        acceptMaxOnCycles,
  input  logic [31:0] maxOnCycles,
  output logic        valveOpen,
  output logic        lockout,
  output logic [2:0]  state,
  output logic [15:0] cycleCount
`ifdef SOAP_DISPENSE_EN
  ,
  output logic        soapPulse
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    SOAP    = 3'd2,
    WATER   = 3'd3,
    HOLD    = 3'd4,
    LOCKOUT = 3'd5
  } stateT;

  localparam logic [31:0] DEB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] MAX_ON_INIT = 32'(MAX_ON_DEFAULT);

  stateT       stateReg, stateNext;
  logic [31:0] debCtrReg, debCtrNext;
  logic [31:0] onTimerReg, onTimerNext;
  logic [31:0] holdTimerReg, holdTimerNext;
  logic [31:0] maxOnHeldReg, maxOnHeldNext;
  logic [15:0] cycleCountReg, cycleCountNext;
  logic        valveOpenReg, lockoutReg;
  logic        enterWater;
  logic        maxOnHit;
`ifdef SOAP_DISPENSE_EN
  localparam logic [31:0] SOAP_LAST = 32'(SOAP_CYCLES - 1);
  logic [31:0] soapTimerReg, soapTimerNext;
  logic        soapPulseReg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg      <= IDLE;
      debCtrReg     <= '0;
      onTimerReg    <= '0;
      holdTimerReg  <= '0;
      maxOnHeldReg  <= MAX_ON_INIT;
      cycleCountReg <= '0;
      valveOpenReg  <= 1'b0;
      lockoutReg    <= 1'b0;
`ifdef SOAP_DISPENSE_EN
      soapTimerReg  <= '0;
      soapPulseReg  <= 1'b0;
`endif
    end else begin
      stateReg      <= stateNext;
      debCtrReg     <= debCtrNext;
      onTimerReg    <= onTimerNext;
      holdTimerReg  <= holdTimerNext;
      maxOnHeldReg  <= maxOnHeldNext;
      cycleCountReg <= cycleCountNext;
      // Outputs are decoded from the next state so they move on the same edge as state.
      valveOpenReg  <= (stateNext == WATER) || (stateNext == HOLD);
      lockoutReg    <= (stateNext == LOCKOUT);
`ifdef SOAP_DISPENSE_EN
      soapTimerReg  <= soapTimerNext;
      soapPulseReg  <= (stateNext == SOAP);
`endif
    end
  end

  always_comb begin
    stateNext      = stateReg;
    debCtrNext     = debCtrReg;
    onTimerNext    = onTimerReg;
    holdTimerNext  = holdTimerReg;
    maxOnHeldNext  = maxOnHeldReg;
    cycleCountNext = cycleCountReg;
    enterWater     = 1'b0;
`ifdef SOAP_DISPENSE_EN
    soapTimerNext  = soapTimerReg;
`endif
    // The compare uses the held limit, so a lowered limit bites one edge after it is latched.
    maxOnHit = (onTimerReg >= (maxOnHeldReg - 32'd1));

    if (acceptMaxOnCycles && (maxOnCycles != 32'd0)) begin
      maxOnHeldNext = maxOnCycles;
    end

    case (stateReg)
      IDLE: begin
        if (waterRequest) begin
          stateNext  = ARM;
          debCtrNext = '0;
        end
      end
      ARM: begin
        if (!waterRequest) begin
          stateNext = IDLE;
        end else if (debCtrReg == DEB_LAST) begin
`ifdef SOAP_DISPENSE_EN
          stateNext     = SOAP;
          soapTimerNext = '0;
`else
          stateNext  = WATER;
          enterWater = 1'b1;
`endif
        end else begin
          debCtrNext = debCtrReg + 32'd1;
        end
      end
`ifdef SOAP_DISPENSE_EN
      SOAP: begin
        if (soapTimerReg == SOAP_LAST) begin
          stateNext  = WATER;
          enterWater = 1'b1;
        end else begin
          soapTimerNext = soapTimerReg + 32'd1;
        end
      end
`endif
      WATER: begin
        if (maxOnHit) begin
          stateNext = LOCKOUT;
        end else begin
          onTimerNext = onTimerReg + 32'd1;
          if (!waterRequest) begin
            stateNext     = HOLD;
            holdTimerNext = '0;
          end
        end
      end
      HOLD: begin
        if (maxOnHit) begin
          stateNext = LOCKOUT;
        end else if (holdTimerReg == HOLD_LAST) begin
          stateNext = IDLE;
        end else begin
          onTimerNext = onTimerReg + 32'd1;
          if (waterRequest) begin
            stateNext = WATER;
          end else begin
            holdTimerNext = holdTimerReg + 32'd1;
          end
        end
      end
      LOCKOUT: begin
        if (!waterRequest) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (enterWater) begin
      onTimerNext = '0;
      if (cycleCountReg != 16'hFFFF) begin
        cycleCountNext = cycleCountReg + 16'd1;
      end
    end
  end

  assign valveOpen  = valveOpenReg;
  assign lockout    = lockoutReg;
  assign state      = stateReg;
  assign cycleCount = cycleCountReg;
`ifdef SOAP_DISPENSE_EN
  assign soapPulse  = soapPulseReg;
`endif

endmodule
